aes_pipe_scheduler: RTL and testbench

Two-requester front end that shares one fully pipelined aes_top core (data_in, key → cryptokey, fixed latency, no stall) between independent clients. It round-robin arbitrates one block per cycle into the core and tags each issued block with its requester ID in a delay line that matches the core latency. Each ciphertext is routed back to its owner as a one-cycle response pulse. A halt/drain handshake lets system control quiesce the core safely.

---
 rtl/aes_pipe_scheduler_if.sv | 41 ++++
 rtl/aes_pipe_scheduler.sv | 165 ++++++++++++++++
 tb/tb_aes_pipe_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pipe_scheduler_if.sv
// aes_pipe_scheduler_if: bundles the two client request/response channels,
// the shared AES core data path and the halt/drain handshake.
//   slave  : the scheduler
//   master : clients, the AES core and system control
interface aes_pipe_scheduler_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_data;
    logic [127:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_data;
    logic [127:0] req1_key;
    logic         rsp0_valid;
    logic [127:0] rsp0_data;
    logic         rsp1_valid;
    logic [127:0] rsp1_data;
    logic [127:0] core_data_in;
    logic [127:0] core_key;
    logic [127:0] core_result;
    logic         halt_req;
    logic         halted;

    modport slave (
        input  req0_valid, req0_data, req0_key,
        input  req1_valid, req1_data, req1_key,
        input  core_result, halt_req,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output core_data_in, core_key, halted
    );

    modport master (
        output req0_valid, req0_data, req0_key,
        output req1_valid, req1_data, req1_key,
        output core_result, halt_req,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  core_data_in, core_key, halted
    );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// aes_pipe_scheduler: round-robin front end sharing one fully pipelined AES
// core between two requesters. Issued blocks carry their requester tag down a
// delay line matched to the core latency; ciphertexts return as one-cycle
// response pulses. halt_req stops issue and drains the pipe.
// Optional build macro AES_SCHED_STATS_EN adds saturating per-requester
// accept counters stat_issued0/stat_issued1.
module aes_pipe_scheduler #(
    parameter int LATENCY = 11,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_pipe_scheduler_if.slave  bus
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_issued0,
    output logic [CNT_W-1:0]     stat_issued1
`endif
);
    // One stage beyond the core latency: the tag must still be present on
    // the edge that captures core_result into the response register.
    localparam int DEPTH = LATENCY + 1;
    localparam int IW    = $clog2(LATENCY + 2);

    if (LATENCY < 1 || CNT_W < 1) begin : g_cfg_check
        $error("aes_pipe_scheduler: LATENCY and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;           // 1: requester 1 wins a tie
    logic [127:0]   core_data_q, core_data_d;
    logic [127:0]   core_key_q, core_key_d;
    logic [DEPTH:1] vld_pipe_q, vld_pipe_d;
    logic [DEPTH:1] tag_pipe_q, tag_pipe_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [127:0]   rsp0_data_q, rsp0_data_d;
    logic [127:0]   rsp1_data_q, rsp1_data_d;
    logic [IW-1:0]  inflight_q, inflight_d;
    logic           run, gnt0, gnt1, acc0, acc1, acc, rsp_evt;

    // Arbitration: a lone requester wins, a tie goes to the favoured one.
    always_comb begin
        run  = (state_q == S_RUN);
        gnt0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);
        acc0 = run && gnt0;
        acc1 = run && gnt1;
        acc  = acc0 || acc1;
    end

    // Issue, tag delay line, response capture and in-flight accounting.
    always_comb begin
        prio_d      = prio_q;
        core_data_d = core_data_q;
        core_key_d  = core_key_q;
        if (acc0) begin
            prio_d      = 1'b1;
            core_data_d = bus.req0_data;
            core_key_d  = bus.req0_key;
        end else if (acc1) begin
            prio_d      = 1'b0;
            core_data_d = bus.req1_data;
            core_key_d  = bus.req1_key;
        end
        vld_pipe_d   = {vld_pipe_q[DEPTH-1:1], acc};
        tag_pipe_d   = {tag_pipe_q[DEPTH-1:1], acc1};
        rsp_evt      = vld_pipe_q[DEPTH];
        rsp0_valid_d = rsp_evt && !tag_pipe_q[DEPTH];
        rsp1_valid_d = rsp_evt &&  tag_pipe_q[DEPTH];
        rsp0_data_d  = rsp0_valid_d ? bus.core_result : rsp0_data_q;
        rsp1_data_d  = rsp1_valid_d ? bus.core_result : rsp1_data_q;
        inflight_d   = inflight_q;
        if (acc && !rsp_evt) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!acc && rsp_evt) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    // Halt/drain next-state logic; a dropped halt_req always resumes issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (bus.halt_req) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!bus.halt_req)          state_d = S_RUN;
                else if (inflight_q == '0)  state_d = S_HALTED;
            end
            S_HALTED: if (!bus.halt_req) state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // Datapath registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q       <= 1'b0;
            core_data_q  <= '0;
            core_key_q   <= '0;
            vld_pipe_q   <= '0;
            tag_pipe_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            inflight_q   <= '0;
        end else begin
            prio_q       <= prio_d;
            core_data_q  <= core_data_d;
            core_key_q   <= core_key_d;
            vld_pipe_q   <= vld_pipe_d;
            tag_pipe_q   <= tag_pipe_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            inflight_q   <= inflight_d;
        end
    end

    assign bus.req0_ready   = acc0;
    assign bus.req1_ready   = acc1;
    assign bus.core_data_in = core_data_q;
    assign bus.core_key     = core_key_q;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp0_data    = rsp0_data_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp1_data    = rsp1_data_q;
    assign bus.halted       = (state_q == S_HALTED);

`ifdef AES_SCHED_STATS_EN
    logic [CNT_W-1:0] st0_q, st0_d, st1_q, st1_d;

    // Saturating accept counters.
    always_comb begin
        st0_d = st0_q;
        st1_d = st1_q;
        if (acc0 && st0_q != '1) st0_d = st0_q + CNT_W'(1);
        if (acc1 && st1_q != '1) st1_d = st1_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st0_q <= '0;
            st1_q <= '0;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
        end
    end

    assign stat_issued0 = st0_q;
    assign stat_issued1 = st1_q;
`endif
endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// tb_aes_pipe_scheduler: drives directed and random traffic into the
// scheduler with a behavioural AES core stub and compares every cycle against
// a transaction-level model (queue of issued blocks with due times).
`timescale 1ns/1ps
module tb_aes_pipe_scheduler;
    localparam int LATENCY = 11;
`ifdef AES_SCHED_STATS_EN
    localparam int CNT_W = 3;
`else
    localparam int CNT_W = 32;
`endif

    localparam logic [127:0] V0_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V0_D = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V0_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V1_K = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] V1_D = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] V1_C = 128'hff0b844a0853bf7c6934ab4364148fb9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_pipe_scheduler_if ifc();

`ifdef AES_SCHED_STATS_EN
    logic [CNT_W-1:0] stat0, stat1;
`endif

    aes_pipe_scheduler #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc)
`ifdef AES_SCHED_STATS_EN
        ,
        .stat_issued0 (stat0),
        .stat_issued1 (stat1)
`endif
    );

    // Stand-in cipher: exact for the two known vectors, a keyed scramble otherwise.
    function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
        if (d == V0_D && k == V0_K) return V0_C;
        if (d == V1_D && k == V1_K) return V1_C;
        return {d[63:0], d[127:64]} ^ {k[31:0], k[127:32]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    // Core stub: fixed LATENCY-cycle pipeline from the registered inputs.
    logic [127:0] core_pipe [LATENCY];
    logic         garbage_en;
    logic [127:0] garbage;
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= cipher(ifc.core_data_in, ifc.core_key);
        garbage      <= {$urandom, $urandom, $urandom, $urandom};
    end
    assign ifc.core_result = garbage_en ? garbage : core_pipe[LATENCY-1];

    // Reference model state.
    typedef struct {
        logic         tag;
        logic [127:0] ct;
        int           due;
    } ent_t;
    ent_t         q[$];
    int           cyc, vectors, errs;
    int           mst;        // 0 run, 1 drain, 2 halted
    logic         fav1;       // requester 1 wins the next tie
    logic         e_v0, e_v1;
    logic [127:0] e_d0, e_d1, e_cd, e_ck;
`ifdef AES_SCHED_STATS_EN
    int           cnt0, cnt1;
`endif

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mst  = 0;
        fav1 = 1'b0;
        e_v0 = 1'b0; e_v1 = 1'b0;
        e_d0 = '0;   e_d1 = '0;
        e_cd = '0;   e_ck = '0;
`ifdef AES_SCHED_STATS_EN
        cnt0 = 0; cnt1 = 0;
`endif
    endtask

    // One clock: check ready, apply the edge to the model, check outputs.
    task automatic step();
        logic v0, v1, w1, a0, a1;
        int   nst;
        #1;
        v0 = ifc.req0_valid;
        v1 = ifc.req1_valid;
        w1 = (v0 && v1) ? fav1 : v1;
        a0 = (mst == 0) && v0 && !w1;
        a1 = (mst == 0) && v1 &&  w1;
        chk("req0_ready", {127'd0, ifc.req0_ready}, {127'd0, a0});
        chk("req1_ready", {127'd0, ifc.req1_ready}, {127'd0, a1});
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            nst = mst;
            if (mst == 0 && ifc.halt_req)        nst = 1;
            else if (mst == 1 && !ifc.halt_req) nst = 0;
            else if (mst == 1 && q.size() == 0)  nst = 2;
            else if (mst == 2 && !ifc.halt_req) nst = 0;
            e_v0 = 1'b0;
            e_v1 = 1'b0;
            if (q.size() != 0 && q[0].due == cyc) begin
                if (q[0].tag) begin e_v1 = 1'b1; e_d1 = q[0].ct; end
                else          begin e_v0 = 1'b1; e_d0 = q[0].ct; end
                void'(q.pop_front());
            end
            if (a0 || a1) begin
                e_cd = a1 ? ifc.req1_data : ifc.req0_data;
                e_ck = a1 ? ifc.req1_key  : ifc.req0_key;
                q.push_back('{tag: a1, ct: cipher(e_cd, e_ck), due: cyc + LATENCY + 1});
                fav1 = a0;
            end
`ifdef AES_SCHED_STATS_EN
            if (a0 && cnt0 < (1 << CNT_W) - 1) cnt0++;
            if (a1 && cnt1 < (1 << CNT_W) - 1) cnt1++;
`endif
            mst = nst;
        end
        cyc++;
        @(negedge clk);
        chk("rsp0_valid",   {127'd0, ifc.rsp0_valid}, {127'd0, e_v0});
        chk("rsp1_valid",   {127'd0, ifc.rsp1_valid}, {127'd0, e_v1});
        chk("rsp0_data",    ifc.rsp0_data, e_d0);
        chk("rsp1_data",    ifc.rsp1_data, e_d1);
        chk("halted",       {127'd0, ifc.halted}, {127'd0, mst == 2});
        chk("core_data_in", ifc.core_data_in, e_cd);
        chk("core_key",     ifc.core_key, e_ck);
`ifdef AES_SCHED_STATS_EN
        chk("stat_issued0", {{(128-CNT_W){1'b0}}, stat0}, 128'(cnt0));
        chk("stat_issued1", {{(128-CNT_W){1'b0}}, stat1}, 128'(cnt1));
`endif
    endtask

    task automatic idle(input int n);
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.req0_valid = 1'b0; ifc.req0_data = V0_D; ifc.req0_key = V0_K;
        ifc.req1_valid = 1'b0; ifc.req1_data = V1_D; ifc.req1_key = V1_K;
        ifc.halt_req   = 1'b0;
        garbage_en     = 1'b0;
        rst            = 1'b0;
        cyc = 0; vectors = 0; errs = 0;
        model_reset();
        @(negedge clk);
        repeat (3) step();
        rst = 1'b1;

        // Single issue from requester 0.
        ifc.req0_valid = 1'b1;
        step();
        idle(LATENCY + 3);

        // Contention: both valid for 12 cycles from a fresh pointer.
        pulse_reset();
        ifc.req0_valid = 1'b1;
        ifc.req1_valid = 1'b1;
        repeat (12) step();
        idle(LATENCY + 3);

        // Drain: 5 blocks, halt while both still request, then release.
        ifc.req0_valid = 1'b1;
        repeat (5) step();
        ifc.halt_req   = 1'b1;
        ifc.req1_valid = 1'b1;
        repeat (LATENCY + 8) step();
        ifc.halt_req = 1'b0;
        repeat (2) step();
        idle(LATENCY + 3);

        // Reset with three blocks in flight, then a fresh request.
        ifc.req1_valid = 1'b1;
        repeat (3) step();
        ifc.req1_valid = 1'b0;
        pulse_reset();
        idle(LATENCY + 2);
        ifc.req1_valid = 1'b1;
        step();
        idle(LATENCY + 3);

        // Idle with a garbage core output.
        garbage_en = 1'b1;
        idle(2 * LATENCY);
        garbage_en = 1'b0;

        // Random traffic with halt toggling and rare resets.
        for (int n = 0; n < 600; n++) begin
            int p;
            p = (n < 200) ? 90 : (n < 400) ? 50 : 20;
            ifc.req0_valid = ($urandom_range(0, 99) < p);
            ifc.req1_valid = ($urandom_range(0, 99) < p);
            if ($urandom_range(0, 3) == 0) begin
                ifc.req0_data = V0_D; ifc.req0_key = V0_K;
            end else begin
                ifc.req0_data = {$urandom, $urandom, $urandom, $urandom};
                ifc.req0_key  = {$urandom, $urandom, $urandom, $urandom};
            end
            ifc.req1_data = {$urandom, $urandom, $urandom, $urandom};
            ifc.req1_key  = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 39) == 0) ifc.halt_req = !ifc.halt_req;
            rst = ($urandom_range(0, 299) != 0);
            step();
        end
        rst          = 1'b1;
        ifc.halt_req = 1'b0;
        idle(LATENCY + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
